// File: rtl/compuertas_logicas_if.sv
// compuertas_logicas_if: operand, enable, select and result signals of the selectable gate
interface compuertas_logicas_if;
    logic       ent1;
    logic       ent2;
    logic       ent3;
    logic       act;
    logic [2:0] sel;
    logic       sal;
    modport master (output ent1, ent2, ent3, act, sel, input sal);
    modport slave (input ent1, ent2, ent3, act, sel, output sal);
endinterface

// File: rtl/compuertas_logicas.sv
// compuertas_logicas: three-input gate picked by sel, gated by act, registered on sal
module compuertas_logicas (
    input logic                  clk,
    input logic                  rst_n,
    compuertas_logicas_if.slave  bus
);
    logic w_and;
    logic w_or;
    logic w_xor;
    logic w_maj;
    logic w_f;
    logic r_sal;
    always_comb begin
        w_and = bus.ent1 & bus.ent2 & bus.ent3;
        w_or  = bus.ent1 | bus.ent2 | bus.ent3;
        w_xor = bus.ent1 ^ bus.ent2 ^ bus.ent3;
        w_maj = (bus.ent1 & bus.ent2) | (bus.ent1 & bus.ent3) | (bus.ent2 & bus.ent3);
        w_f   = bus.sel == 3'b001 ? w_and  :
                bus.sel == 3'b010 ? w_or   :
                bus.sel == 3'b011 ? ~w_and :
                bus.sel == 3'b100 ? ~w_or  :
                bus.sel == 3'b101 ? w_xor  :
                bus.sel == 3'b110 ? ~w_xor :
                bus.sel == 3'b111 ? w_maj  : 1'b0;
    end
    // act low wins over every function, including the inverting ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sal <= 1'b0;
        else        r_sal <= bus.act & w_f;
    end
    assign bus.sal = r_sal;
endmodule

// File: tb/tb_compuertas_logicas.sv
// tb_compuertas_logicas: randomized and directed checks against a counting-based gate model
module tb_compuertas_logicas;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    compuertas_logicas_if bus ();
    compuertas_logicas dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // model from the number of ones among the operands
    function automatic logic model(input logic [2:0] sel, input logic a, input logic b, input logic c);
        int n;
        n = int'(a) + int'(b) + int'(c);
        case (sel)
            3'd1:    return n == 3;
            3'd2:    return n > 0;
            3'd3:    return n != 3;
            3'd4:    return n == 0;
            3'd5:    return (n % 2) == 1;
            3'd6:    return (n % 2) == 0;
            3'd7:    return n >= 2;
            default: return 1'b0;
        endcase
    endfunction
    task automatic drive(input logic [2:0] ops, input logic act, input logic [2:0] sel);
        @(negedge clk);
        bus.ent1 = ops[2];
        bus.ent2 = ops[1];
        bus.ent3 = ops[0];
        bus.act  = act;
        bus.sel  = sel;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(3'b000, 1'b1, 3'b011);
            checks++;
            if (bus.sal !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: sal=%b expected 0", i, bus.sal);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.sal !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: sal=%b expected 1", bus.sal);
        end
    endtask
    task automatic test_enable_gating();
        for (int s = 0; s < 8; s++)
            for (int o = 0; o < 8; o++) begin
                drive(3'(o), 1'b0, 3'(s));
                checks++;
                if (bus.sal !== 1'b0) begin
                    errors++;
                    $display("FAIL act_low sel=%0d ops=%0d: sal=%b expected 0", s, o, bus.sal);
                end
            end
        drive(3'b000, 1'b1, 3'b100);
        checks++;
        if (bus.sal !== 1'b1) begin
            errors++;
            $display("FAIL act_reenable: sal=%b expected 1", bus.sal);
        end
    endtask
    task automatic test_truth_table();
        logic [2:0] ov;
        logic       exp;
        for (int s = 0; s < 8; s++)
            for (int o = 0; o < 8; o++) begin
                ov  = 3'(o);
                exp = model(3'(s), ov[2], ov[1], ov[0]);
                drive(ov, 1'b1, 3'(s));
                checks++;
                if (bus.sal !== exp) begin
                    errors++;
                    $display("FAIL truth sel=%0d ops=%b: sal=%b expected %b", s, ov, bus.sal, exp);
                end
            end
    endtask
    task automatic test_latency();
        drive(3'b000, 1'b1, 3'b001);
        drive(3'b111, 1'b1, 3'b001);
        checks++;
        if (bus.sal !== 1'b1) begin
            errors++;
            $display("FAIL latency_hit: sal=%b expected 1", bus.sal);
        end
        @(negedge clk);
        bus.ent1 = 1'b0;
        bus.ent2 = 1'b0;
        bus.ent3 = 1'b0;
        #1;
        checks++;
        if (bus.sal !== 1'b1) begin
            errors++;
            $display("FAIL latency_hold: sal=%b expected 1", bus.sal);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.sal !== 1'b0) begin
            errors++;
            $display("FAIL latency_drop: sal=%b expected 0", bus.sal);
        end
    endtask
    task automatic test_simultaneous();
        drive(3'b011, 1'b1, 3'b010);
        checks++;
        if (bus.sal !== 1'b1) begin
            errors++;
            $display("FAIL simul_or: sal=%b expected 1", bus.sal);
        end
        drive(3'b011, 1'b1, 3'b001);
        checks++;
        if (bus.sal !== 1'b0) begin
            errors++;
            $display("FAIL simul_and: sal=%b expected 0", bus.sal);
        end
    endtask
    task automatic test_mid_reset();
        drive(3'b111, 1'b1, 3'b010);
        checks++;
        if (bus.sal !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: sal=%b expected 1", bus.sal);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.sal !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: sal=%b expected 0", bus.sal);
        end
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.sal !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after_release: sal=%b expected 0", bus.sal);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.sal !== 1'b1) begin
            errors++;
            $display("FAIL midrst_recover: sal=%b expected 1", bus.sal);
        end
    endtask
    task automatic test_random();
        logic [2:0] ov;
        logic [2:0] sv;
        logic       av;
        logic       exp;
        for (int i = 0; i < 300; i++) begin
            ov  = 3'($urandom_range(7));
            sv  = 3'($urandom_range(7));
            av  = ($urandom_range(3) != 0);
            exp = av ? model(sv, ov[2], ov[1], ov[0]) : 1'b0;
            drive(ov, av, sv);
            checks++;
            if (bus.sal !== exp) begin
                errors++;
                $display("FAIL random %0d act=%b sel=%0d ops=%b: sal=%b expected %b", i, av, sv, ov, bus.sal, exp);
            end
        end
    endtask
    initial begin
        bus.ent1 = 1'b0;
        bus.ent2 = 1'b0;
        bus.ent3 = 1'b0;
        bus.act  = 1'b0;
        bus.sel  = 3'b000;
        #2;
        checks++;
        if (bus.sal !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: sal=%b expected 0", bus.sal);
        end
        test_reset();
        test_enable_gating();
        test_truth_table();
        test_latency();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
